// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock controller: state encodings,
// BCD wrap limits and the alarm time loaded at reset.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_AL_HR   = 3'd3,
    ST_AL_MIN  = 3'd4,
    ST_RINGING = 3'd5,
    ST_SNOOZE  = 3'd6
  } state_t;

  localparam logic [7:0] HOUR_LIMIT  = 8'h23;
  localparam logic [7:0] MIN_LIMIT   = 8'h59;
  localparam logic [7:0] RST_AL_HOUR = 8'h06;
  localparam logic [7:0] RST_AL_MIN  = 8'h00;

endpackage

// File: rtl/bcd_wrap_inc.sv
// Two-digit BCD incrementer: returns 0x00 when the input equals the wrap
// limit, otherwise adds one with low-digit carry into the high digit.
module bcd_wrap_inc (
  input  logic [7:0] i_bcd,
  input  logic [7:0] i_limit,
  output logic [7:0] o_bcd
);

  always_comb begin
    o_bcd = i_bcd;
    if (i_bcd == i_limit) begin
      o_bcd = '0;
    end else if (i_bcd[3:0] == 4'd9) begin
      o_bcd = {i_bcd[7:4] + 4'd1, 4'd0};
    end else begin
      o_bcd = {i_bcd[7:4], i_bcd[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: time/alarm setting modes, alarm match detection,
// ringing with auto-timeout and snooze, and counter advance enables.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_MIN   = 1
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       tick_min,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_arm,
  input  logic       btn_snooze,
  input  logic       btn_off,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  output logic       min_inc,
  output logic       hour_inc,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_min,
  output logic       alarm_en,
  output logic       ring,
  output logic [2:0] mode
);

  localparam logic [3:0] SNZ_LOAD  = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LOAD = 4'(RING_MIN);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_ring_cnt, w_ring_cnt_nxt;
  logic [3:0] r_snz_cnt, w_snz_cnt_nxt;
  logic       r_alarm_en, w_alarm_en_nxt;
  logic [7:0] r_al_hour, w_al_hour_nxt;
  logic [7:0] r_al_min, w_al_min_nxt;
  logic       r_min_inc, w_min_inc_nxt;
  logic       r_hour_inc, w_hour_inc_nxt;
  logic       r_match_q;
  logic       w_match, w_match_rise;
  logic [7:0] w_hour_plus, w_min_plus;

  bcd_wrap_inc u_hour_inc (
    .i_bcd   (r_al_hour),
    .i_limit (HOUR_LIMIT),
    .o_bcd   (w_hour_plus)
  );

  bcd_wrap_inc u_min_inc (
    .i_bcd   (r_al_min),
    .i_limit (MIN_LIMIT),
    .o_bcd   (w_min_plus)
  );

  assign w_match      = r_alarm_en && (cur_hour == r_al_hour) && (cur_min == r_al_min);
  assign w_match_rise = w_match && !r_match_q;

  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
    w_snz_cnt_nxt  = r_snz_cnt;
    w_alarm_en_nxt = r_alarm_en;
    w_al_hour_nxt  = r_al_hour;
    w_al_min_nxt   = r_al_min;
    w_min_inc_nxt  = 1'b0;
    w_hour_inc_nxt = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        w_min_inc_nxt = tick_min;
        // A rising match swallows any mode/arm press in the same cycle
        if (w_match_rise) begin
          w_state_nxt    = ST_RINGING;
          w_ring_cnt_nxt = RING_LOAD;
        end else begin
          if (btn_mode) w_state_nxt = ST_SET_HR;
          if (btn_arm)  w_alarm_en_nxt = !r_alarm_en;
        end
      end
      ST_SET_HR: begin
        w_hour_inc_nxt = btn_inc;
        if (btn_mode) w_state_nxt = ST_SET_MIN;
      end
      ST_SET_MIN: begin
        w_min_inc_nxt = btn_inc;
        if (btn_mode) w_state_nxt = ST_AL_HR;
      end
      ST_AL_HR: begin
        w_min_inc_nxt = tick_min;
        if (btn_inc)  w_al_hour_nxt = w_hour_plus;
        if (btn_mode) w_state_nxt = ST_AL_MIN;
      end
      ST_AL_MIN: begin
        w_min_inc_nxt = tick_min;
        if (btn_inc)  w_al_min_nxt = w_min_plus;
        if (btn_mode) w_state_nxt = ST_RUN;
      end
      ST_RINGING: begin
        w_min_inc_nxt = tick_min;
        if (btn_off) begin
          w_state_nxt    = ST_RUN;
          w_ring_cnt_nxt = '0;
        end else if (btn_snooze) begin
          w_state_nxt    = ST_SNOOZE;
          w_snz_cnt_nxt  = SNZ_LOAD;
          w_ring_cnt_nxt = '0;
        end else if (tick_min) begin
          if (r_ring_cnt <= 4'd1) begin
            w_state_nxt    = ST_RUN;
            w_ring_cnt_nxt = '0;
          end else begin
            w_ring_cnt_nxt = r_ring_cnt - 4'd1;
          end
        end
      end
      ST_SNOOZE: begin
        w_min_inc_nxt = tick_min;
        if (btn_off) begin
          w_state_nxt   = ST_RUN;
          w_snz_cnt_nxt = '0;
        end else if (tick_min) begin
          if (r_snz_cnt <= 4'd1) begin
            w_state_nxt    = ST_RINGING;
            w_ring_cnt_nxt = RING_LOAD;
            w_snz_cnt_nxt  = '0;
          end else begin
            w_snz_cnt_nxt = r_snz_cnt - 4'd1;
          end
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_alarm_en <= 1'b0;
      r_al_hour  <= RST_AL_HOUR;
      r_al_min   <= RST_AL_MIN;
      r_min_inc  <= 1'b0;
      r_hour_inc <= 1'b0;
      r_match_q  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_snz_cnt  <= w_snz_cnt_nxt;
      r_alarm_en <= w_alarm_en_nxt;
      r_al_hour  <= w_al_hour_nxt;
      r_al_min   <= w_al_min_nxt;
      r_min_inc  <= w_min_inc_nxt;
      r_hour_inc <= w_hour_inc_nxt;
      r_match_q  <= w_match;
    end
  end

  assign min_inc    = r_min_inc;
  assign hour_inc   = r_hour_inc;
  assign alarm_hour = r_al_hour;
  assign alarm_min  = r_al_min;
  assign alarm_en   = r_alarm_en;
  assign ring       = (r_state == ST_RINGING);
  assign mode       = r_state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl.
module tb_alarm_ctrl;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       tick_min = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_arm = 1'b0;
  logic       btn_snooze = 1'b0, btn_off = 1'b0;
  logic [7:0] cur_hour = 8'h00, cur_min = 8'h00;
  logic       min_inc, hour_inc, alarm_en, ring;
  logic [7:0] alarm_hour, alarm_min;
  logic [2:0] mode;

  int checks = 0;
  int errors = 0;

  alarm_ctrl #(.SNOOZE_MIN(5), .RING_MIN(1)) dut (
    .clkin      (clkin),
    .reset      (reset),
    .tick_min   (tick_min),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_arm    (btn_arm),
    .btn_snooze (btn_snooze),
    .btn_off    (btn_off),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .min_inc    (min_inc),
    .hour_inc   (hour_inc),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_en   (alarm_en),
    .ring       (ring),
    .mode       (mode)
  );

  always #5 clkin = ~clkin;

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Arm the alarm (06:00 after reset) and walk current time 05:59 -> 06:00.
  task automatic enter_ringing(input logic arm);
    cur_hour = 8'h05; cur_min = 8'h59;
    if (arm) begin
      btn_arm = 1'b1; step(); btn_arm = 1'b0;
    end
    step();
    cur_hour = 8'h06; cur_min = 8'h00;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; tick_min = 1'b1; btn_mode = 1'b1; btn_arm = 1'b1;
    step();
    reset = 1'b0; tick_min = 1'b0; btn_mode = 1'b0; btn_arm = 1'b0;
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL rst_mode got %0d exp 0", mode); end
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL rst_ring got %b exp 0", ring); end
    checks++; if (alarm_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", alarm_en); end
    checks++; if (alarm_hour !== 8'h06) begin errors++; $display("FAIL rst_ahour got %h exp 06", alarm_hour); end
    checks++; if (alarm_min !== 8'h00) begin errors++; $display("FAIL rst_amin got %h exp 00", alarm_min); end
    checks++; if (min_inc !== 1'b0) begin errors++; $display("FAIL rst_mininc got %b exp 0", min_inc); end
    checks++; if (hour_inc !== 1'b0) begin errors++; $display("FAIL rst_hourinc got %b exp 0", hour_inc); end
    tick_min = 1'b1; step(); tick_min = 1'b0;
    checks++; if (min_inc !== 1'b1) begin errors++; $display("FAIL run_tick got %b exp 1", min_inc); end
    step();
    checks++; if (min_inc !== 1'b0) begin errors++; $display("FAIL run_tick_clr got %b exp 0", min_inc); end
  endtask

  task automatic test_mode_inc();
    int h;
    int m;
    logic [7:0] e;
    do_reset();
    cur_hour = 8'h00; cur_min = 8'h00;
    for (int i = 1; i <= 3; i++) begin
      btn_mode = 1'b1; step(); btn_mode = 1'b0;
      checks++; if (mode !== 3'(i)) begin errors++; $display("FAIL mode_cycle got %0d exp %0d", mode, i); end
    end
    h = 6;
    for (int i = 0; i < 18; i++) begin
      btn_inc = 1'b1; step(); btn_inc = 1'b0;
      h = (h + 1) % 24;
      e = {4'(h / 10), 4'(h % 10)};
      checks++; if (alarm_hour !== e) begin errors++; $display("FAIL al_hour_inc got %h exp %h", alarm_hour, e); end
    end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    checks++; if (mode !== 3'd4) begin errors++; $display("FAIL mode_almin got %0d exp 4", mode); end
    m = 0;
    for (int i = 0; i < 62; i++) begin
      btn_inc = 1'b1; step(); btn_inc = 1'b0;
      m = (m + 1) % 60;
      e = {4'(m / 10), 4'(m % 10)};
      checks++; if (alarm_min !== e) begin errors++; $display("FAIL al_min_inc got %h exp %h", alarm_min, e); end
      checks++; if (min_inc !== 1'b0) begin errors++; $display("FAIL al_min_no_inc got %b exp 0", min_inc); end
    end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL mode_back_run got %0d exp 0", mode); end
  endtask

  task automatic test_set_time();
    do_reset();
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    tick_min = 1'b1; btn_inc = 1'b1; step(); tick_min = 1'b0; btn_inc = 1'b0;
    checks++; if (hour_inc !== 1'b1) begin errors++; $display("FAIL sethr_hourinc got %b exp 1", hour_inc); end
    checks++; if (min_inc !== 1'b0) begin errors++; $display("FAIL sethr_mininc got %b exp 0", min_inc); end
    step();
    checks++; if (hour_inc !== 1'b0) begin errors++; $display("FAIL sethr_hourinc_clr got %b exp 0", hour_inc); end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    tick_min = 1'b1; step(); tick_min = 1'b0;
    checks++; if (min_inc !== 1'b0) begin errors++; $display("FAIL setmin_tick got %b exp 0", min_inc); end
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    checks++; if (min_inc !== 1'b1) begin errors++; $display("FAIL setmin_inc got %b exp 1", min_inc); end
    checks++; if (hour_inc !== 1'b0) begin errors++; $display("FAIL setmin_hourinc got %b exp 0", hour_inc); end
    btn_arm = 1'b1; step(); btn_arm = 1'b0;
    checks++; if (alarm_en !== 1'b0) begin errors++; $display("FAIL arm_outside_run got %b exp 0", alarm_en); end
  endtask

  task automatic test_ring();
    do_reset();
    cur_hour = 8'h05; cur_min = 8'h59;
    btn_arm = 1'b1; step(); btn_arm = 1'b0;
    checks++; if (alarm_en !== 1'b1) begin errors++; $display("FAIL arm got %b exp 1", alarm_en); end
    step();
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL ring_early got %b exp 0", ring); end
    cur_hour = 8'h06; cur_min = 8'h00; btn_mode = 1'b1; btn_arm = 1'b1;
    step();
    btn_mode = 1'b0; btn_arm = 1'b0;
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL ring_on_match got %b exp 1", ring); end
    checks++; if (mode !== 3'd5) begin errors++; $display("FAIL match_beats_mode got %0d exp 5", mode); end
    checks++; if (alarm_en !== 1'b1) begin errors++; $display("FAIL match_beats_arm got %b exp 1", alarm_en); end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    checks++; if (mode !== 3'd5) begin errors++; $display("FAIL mode_ignored_ring got %0d exp 5", mode); end
    btn_off = 1'b1; step(); btn_off = 1'b0;
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL off_ring got %b exp 0", ring); end
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL off_mode got %0d exp 0", mode); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ring !== 1'b0) begin errors++; $display("FAIL no_rering got %b exp 0", ring); end
    end
    checks++; if (alarm_en !== 1'b1) begin errors++; $display("FAIL en_kept_off got %b exp 1", alarm_en); end
    enter_ringing(1'b0);
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL ring_again got %b exp 1", ring); end
    tick_min = 1'b1; step(); tick_min = 1'b0;
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL ring_timeout got %0d exp 0", mode); end
    checks++; if (min_inc !== 1'b1) begin errors++; $display("FAIL ring_tick_mininc got %b exp 1", min_inc); end
  endtask

  task automatic test_snooze();
    do_reset();
    enter_ringing(1'b1);
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL snz_pre_ring got %b exp 1", ring); end
    btn_snooze = 1'b1; step(); btn_snooze = 1'b0;
    checks++; if (mode !== 3'd6) begin errors++; $display("FAIL snz_mode got %0d exp 6", mode); end
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL snz_ring got %b exp 0", ring); end
    for (int k = 1; k <= 5; k++) begin
      tick_min = 1'b1; step(); tick_min = 1'b0;
      checks++; if (min_inc !== 1'b1) begin errors++; $display("FAIL snz_mininc got %b exp 1", min_inc); end
      if (k < 5) begin
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL snz_tick%0d ring got %b exp 0", k, ring); end
      end else begin
        checks++; if (ring !== 1'b1) begin errors++; $display("FAIL snz_rering got %b exp 1", ring); end
        checks++; if (mode !== 3'd5) begin errors++; $display("FAIL snz_rering_mode got %0d exp 5", mode); end
      end
    end
    btn_off = 1'b1; btn_snooze = 1'b1; step(); btn_off = 1'b0; btn_snooze = 1'b0;
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL off_beats_snooze got %0d exp 0", mode); end
    checks++; if (alarm_en !== 1'b1) begin errors++; $display("FAIL en_kept_snz got %b exp 1", alarm_en); end
    enter_ringing(1'b0);
    btn_snooze = 1'b1; step(); btn_snooze = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick_min = 1'b1; step(); tick_min = 1'b0;
    end
    checks++; if (mode !== 3'd6) begin errors++; $display("FAIL snz_4ticks got %0d exp 6", mode); end
    tick_min = 1'b1; btn_off = 1'b1; step(); tick_min = 1'b0; btn_off = 1'b0;
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL off_beats_tick got %0d exp 0", mode); end
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL off_beats_tick_ring got %b exp 0", ring); end
  endtask

  task automatic test_reset_in_snooze();
    do_reset();
    enter_ringing(1'b1);
    btn_snooze = 1'b1; step(); btn_snooze = 1'b0;
    checks++; if (mode !== 3'd6) begin errors++; $display("FAIL rsnz_pre got %0d exp 6", mode); end
    reset = 1'b1; tick_min = 1'b1; btn_arm = 1'b1;
    step();
    reset = 1'b0; tick_min = 1'b0; btn_arm = 1'b0;
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL rsnz_mode got %0d exp 0", mode); end
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL rsnz_ring got %b exp 0", ring); end
    checks++; if (alarm_en !== 1'b0) begin errors++; $display("FAIL rsnz_en got %b exp 0", alarm_en); end
    checks++; if (alarm_hour !== 8'h06) begin errors++; $display("FAIL rsnz_ahour got %h exp 06", alarm_hour); end
    checks++; if (alarm_min !== 8'h00) begin errors++; $display("FAIL rsnz_amin got %h exp 00", alarm_min); end
    checks++; if (min_inc !== 1'b0) begin errors++; $display("FAIL rsnz_mininc got %b exp 0", min_inc); end
  endtask

  initial begin
    test_reset();
    test_mode_inc();
    test_set_time();
    test_ring();
    test_snooze();
    test_reset_in_snooze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter SNOOZE_MIN, default 5, snooze length in minute ticks (1-9).
REQ-002 SHALL have parameter RING_MIN, default 1, ring auto-timeout in minute ticks (1-9).
REQ-003 SHALL have port clkin  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the clkin rising edge.
REQ-005 SHALL have port tick_min  input  1  one-cycle pulse per elapsed minute from the time base.
REQ-006 SHALL have ports btn_mode, btn_inc, btn_arm, btn_snooze, btn_off  input  1 each  debounced one-cycle pulses.
REQ-007 SHALL have ports cur_hour, cur_min  input  8 each  BCD current time from the hour/minute counters.
REQ-008 SHALL have ports min_inc, hour_inc  output  1 each  registered one-cycle advance enables to the minute/hour counters.
REQ-009 SHALL have ports alarm_hour, alarm_min  output  8 each  BCD alarm time.
REQ-010 SHALL have ports alarm_en, ring  output  1 each  alarm armed, and buzzer drive.
REQ-011 SHALL have port mode  output  3  current state encoding.

Function
REQ-012 SHALL implement states RUN=0, SET_HR=1, SET_MIN=2, AL_HR=3, AL_MIN=4, RINGING=5, SNOOZE=6; mode reflects the state register.
REQ-013 SHALL, on btn_mode, cycle RUN->SET_HR->SET_MIN->AL_HR->AL_MIN->RUN; btn_mode ignored in RINGING/SNOOZE.
REQ-014 SHALL, in RUN/AL_HR/AL_MIN/RINGING/SNOOZE, assert min_inc the cycle after tick_min (latency 1).
REQ-015 SHALL suppress min_inc from tick_min in SET_HR/SET_MIN (time frozen while setting).
REQ-016 SHALL, in SET_HR, assert hour_inc the cycle after btn_inc; in SET_MIN, assert min_inc the cycle after btn_inc.
REQ-017 SHALL, in AL_HR, increment alarm_hour BCD on btn_inc, wrapping 0x23->0x00; in AL_MIN, increment alarm_min BCD, wrapping 0x59->0x00; low digit 9 rolls to 0 with high-digit carry.
REQ-018 SHALL toggle alarm_en on btn_arm in RUN only.
REQ-019 SHALL compute match = alarm_en && cur_hour==alarm_hour && cur_min==alarm_min, register it as match_q, and enter RINGING from RUN only on match && !match_q (rising edge; no re-trigger within the same minute).
REQ-020 SHALL assert ring exactly while in RINGING, loading a ring counter with RING_MIN on entry.
REQ-021 SHALL, in RINGING: btn_off -> RUN; btn_snooze -> SNOOZE with snooze counter loaded SNOOZE_MIN; tick_min decrements ring counter, counter reaching 0 -> RUN.
REQ-022 SHALL, in SNOOZE: tick_min decrements snooze counter; reaching 0 -> RINGING (ring counter reloaded); btn_off -> RUN.
REQ-023 SHALL resolve simultaneous events: btn_off beats btn_snooze; rising match beats btn_mode/btn_arm in RUN; tick-driven transition and button in the same cycle -> button wins.
REQ-024 SHALL keep alarm_en unchanged by RINGING/SNOOZE exits.

Reset
REQ-025 SHALL on reset set state RUN, min_inc=0, hour_inc=0, ring=0, alarm_en=0, alarm_hour=0x06, alarm_min=0x00, match_q=0, counters 0.
REQ-026 SHALL let reset override all inputs in that cycle, including mid-RINGING or mid-SNOOZE.

Structure
REQ-027 SHALL place state encodings, BCD limits 0x23/0x59 and reset alarm time 0x06:00 in shared package alarm_pkg.
REQ-028 SHALL instantiate combinational sub-module bcd_wrap_inc (8-bit BCD in, wrap limit in, 8-bit BCD out) twice for the alarm registers.

Verification
REQ-029 SHALL verify: reset, btn_mode x4 then btn_inc x3 in AL_MIN from 0x59 -> alarm_min 0x00,0x01,0x02, mode returns 0 after 5th btn_mode.
REQ-030 SHALL verify: alarm 06:00 armed, cur steps 05:59->06:00 -> ring=1 next cycle; btn_off -> ring=0, held at 06:00 no re-ring.
REQ-031 SHALL verify: ringing, btn_snooze, SNOOZE_MIN=5 ticks -> ring reasserts after 5th tick; btn_off+btn_snooze same cycle -> RUN.
REQ-032 SHALL verify: SET_HR with tick_min and btn_inc same cycle -> hour_inc=1, min_inc=0 next cycle.
REQ-033 SHALL verify: reset asserted in SNOOZE -> next cycle mode=0, ring=0, alarm_en=0, alarm 0x06:0x00.
